// File: rtl/seven_seg_scan_ctrl.sv
// Scan controller for a multi-digit common-anode 7-seg display.
// Ports: clk_i/rst_i, value_i+load_i (frame-synced), blank_i, lz_en_i, digit_o, an_o, frame_o.
module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int ON_CYCLES  = 100000,
  parameter int GAP_CYCLES = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [4*NUM_DIGITS-1:0] value_i,
  input  logic                    load_i,
  input  logic [NUM_DIGITS-1:0]   blank_i,
  input  logic                    lz_en_i,
  output logic [3:0]              digit_o,
  output logic [NUM_DIGITS-1:0]   an_o,
  output logic                    frame_o
);

  localparam int DW   = 4 * NUM_DIGITS;
  localparam int IW   = $clog2(NUM_DIGITS);
  localparam int MAXC = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [CW-1:0] ON_LAST  = CW'(ON_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  typedef enum logic {
    S_GAP = 1'b0,
    S_ON  = 1'b1
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [IW-1:0]   idx, idx_n;
  logic [DW-1:0]   shadow, shadow_n;
  logic [DW-1:0]   pending, pending_n;
  logic            pend_vld, pvld_n;
  logic            boundary;

  logic [3:0]            digit_n;
  logic [NUM_DIGITS-1:0] an_n;
  logic                  frame_n;
  logic                  allz;
  logic                  zero_hi;
  logic                  supp;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= S_GAP;
      cnt      <= '0;
      idx      <= '0;
      shadow   <= '0;
      pending  <= '0;
      pend_vld <= 1'b0;
      digit_o  <= 4'h0;
      an_o     <= '1;
      frame_o  <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      idx      <= idx_n;
      shadow   <= shadow_n;
      pending  <= pending_n;
      pend_vld <= pvld_n;
      digit_o  <= digit_n;
      an_o     <= an_n;
      frame_o  <= frame_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt + 1'b1;
    idx_n     = idx;
    shadow_n  = shadow;
    pending_n = pending;
    pvld_n    = pend_vld;
    boundary  = 1'b0;

    if (load_i) begin
      pending_n = value_i;
      pvld_n    = 1'b1;
    end

    unique case (state)
      S_GAP: begin
        if (cnt == GAP_LAST) begin
          state_n = S_ON;
          cnt_n   = '0;
        end
      end
      S_ON: begin
        if (cnt == ON_LAST) begin
          state_n = S_GAP;
          cnt_n   = '0;
          if (idx == IDX_LAST) begin
            idx_n    = '0;
            boundary = 1'b1;
          end else begin
            idx_n = idx + 1'b1;
          end
        end
      end
      default: begin
        state_n = S_GAP;
        cnt_n   = '0;
      end
    endcase

    // A load on the boundary edge itself bypasses pending.
    if (boundary) begin
      if (load_i) begin
        shadow_n = value_i;
      end else if (pend_vld) begin
        shadow_n = pending;
      end
      pvld_n = 1'b0;
    end
  end

  // Outputs are computed from next state so the registered
  // outputs line up with the state they describe.
  always_comb begin
    allz    = 1'b1;
    zero_hi = 1'b0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      allz = allz & (shadow_n[4*k +: 4] == 4'h0);
      if (idx_n == IW'(k)) begin
        zero_hi = allz;
      end
    end

    supp = blank_i[idx_n]
         | (lz_en_i & (idx_n != '0) & zero_hi);

    digit_n = shadow_n[4*idx_n +: 4];

    an_n = '1;
    if (state_n == S_ON) begin
      an_n[idx_n] = supp;
    end

    frame_n = (state_n == S_ON)
            & (idx_n == IDX_LAST)
            & (cnt_n == ON_LAST);
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl.
// Geometry: 4 digits, ON=8, GAP=2 (slot 10, frame 40).
module tb_seven_seg_scan_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [15:0] value_i = '0;
  logic        load_i = 1'b0;
  logic [3:0]  blank_i = '0;
  logic        lz_en_i = 1'b0;
  logic [3:0]  digit_o;
  logic [3:0]  an_o;
  logic        frame_o;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  seven_seg_scan_ctrl #(
    .NUM_DIGITS (4),
    .ON_CYCLES  (8),
    .GAP_CYCLES (2)
  ) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .value_i (value_i),
    .load_i  (load_i),
    .blank_i (blank_i),
    .lz_en_i (lz_en_i),
    .digit_o (digit_o),
    .an_o    (an_o),
    .frame_o (frame_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Expected outputs for cycle n of a scan; lit = digits allowed on,
  // shv = value being displayed in this frame.
  task automatic chk_cycle(string tag, int n, logic [3:0] lit,
                           logic [15:0] shv);
    int         slot;
    int         k;
    logic [3:0] ea;
    slot = n % 10;
    k    = (n / 10) % 4;
    ea   = 4'hF;
    if (slot >= 2 && lit[k]) ea[k] = 1'b0;
    cyc = n;
    chk({tag, "_an"}, 32'(an_o), 32'(ea));
    chk({tag, "_dig"}, 32'(digit_o), 32'(shv[k*4 +: 4]));
    chk({tag, "_frm"}, 32'(frame_o), 32'((n % 40) == 39));
  endtask

  task automatic do_reset();
    rst_i   = 1'b1;
    load_i  = 1'b0;
    blank_i = '0;
    lz_en_i = 1'b0;
    value_i = '0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  initial begin
    // Reset, scan order and frame-synchronous load
    do_reset();
    for (int n = 0; n < 80; n++) begin
      load_i  = (n == 15);
      value_i = 16'h1A2F;
      chk_cycle("scan", n, 4'hF, (n < 40) ? 16'h0 : 16'h1A2F);
      @(negedge clk_i);
    end

    // Overwrite, with second load on the boundary edge
    do_reset();
    for (int n = 0; n < 90; n++) begin
      load_i  = (n == 20) || (n == 39);
      value_i = (n == 39) ? 16'h2222 : 16'h1111;
      chk_cycle("ovw", n, 4'hF, (n < 40) ? 16'h0 : 16'h2222);
      if (n == 25) chk("ovw_pvld_set", 32'(dut.pend_vld), 32'd1);
      if (n == 45) chk("ovw_pvld_clr", 32'(dut.pend_vld), 32'd0);
      @(negedge clk_i);
    end

    // Leading-zero suppression: 0000, 0005, then 0305
    do_reset();
    lz_en_i = 1'b1;
    for (int n = 0; n < 120; n++) begin
      load_i  = (n == 0) || (n == 50);
      value_i = (n == 0) ? 16'h0005 : 16'h0305;
      chk_cycle("lz", n, (n < 80) ? 4'b0001 : 4'b0111,
                (n < 40) ? 16'h0 : (n < 80) ? 16'h0005 : 16'h0305);
      @(negedge clk_i);
    end

    // Blanking of digit 2, released in the middle of its window
    do_reset();
    for (int n = 0; n < 80; n++) begin
      blank_i = (n < 65) ? 4'b0100 : 4'b0000;
      chk_cycle("blk", n, (n <= 65) ? 4'b1011 : 4'hF, 16'h0);
      @(negedge clk_i);
    end

    // Reset during digit 2 with a load pending
    do_reset();
    for (int n = 0; n < 65; n++) begin
      load_i  = (n == 3) || (n == 45);
      value_i = (n == 3) ? 16'hABCD : 16'h7777;
      chk_cycle("mrst", n, 4'hF, (n < 40) ? 16'h0 : 16'hABCD);
      @(negedge clk_i);
    end
    load_i = 1'b0;
    chk_cycle("mrst", 65, 4'hF, 16'hABCD);
    rst_i = 1'b1;
    #1;
    chk("mrst_an_now", 32'(an_o), 32'hF);
    chk("mrst_dig_now", 32'(digit_o), 32'h0);
    chk("mrst_frm_now", 32'(frame_o), 32'h0);
    chk("mrst_pvld_now", 32'(dut.pend_vld), 32'h0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    for (int n = 0; n < 120; n++) begin
      chk_cycle("post", n, 4'hF, 16'h0);
      @(negedge clk_i);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_ctrl.md
# seven_seg_scan_ctrl

Time-multiplexed scan controller for a multi-digit common-anode seven-segment display. It holds a multi-digit hex value and cycles through the digits one at a time. For each digit it presents that digit's 4-bit nibble to the existing `seven_seg_display` decoder and drives the matching active-low anode enable. Updates are frame-synchronous, so a digit never shows a torn value. Anti-ghosting gaps, per-digit blanking and leading-zero suppression are built in.

## Interface
- `NUM_DIGITS`, default 4: number of digits scanned (2..8).
- `ON_CYCLES`, default 100000: cycles each digit is lit per slot (≥1).
- `GAP_CYCLES`, default 2: cycles all anodes are off before each digit is lit (≥1).
- `clk_i`, input, 1: single clock; all state updates on its rising edge.
- `rst_i`, input, 1: reset, asynchronous and active-high.
- `value_i`, input, 4*NUM_DIGITS: value to display; nibble k is digit k; digit 0 is the least significant (rightmost).
- `load_i`, input, 1: one-cycle strobe that captures `value_i` for the next frame.
- `blank_i`, input, NUM_DIGITS: per-digit force-off, sampled live.
- `lz_en_i`, input, 1: leading-zero suppression enable, sampled live.
- `digit_o`, output, 4: nibble of the current digit; connects to the decoder's `a_i`.
- `an_o`, output, NUM_DIGITS: anode enables, active-low, one-cold or all-ones.
- `frame_o`, output, 1: one-cycle pulse on the last cycle of each frame.

## Operation
- Registers:
  - `shadow`: the displayed value.
  - `pending` and `pend_vld`: a captured value not yet displayed.
  - `idx`: current digit.
  - `cnt`: slot counter.
  - `state`: GAP or ON.
- FSM, reset state GAP:
  - GAP: `an_o` all ones. Stays `GAP_CYCLES` cycles, then goes to ON.
  - ON: lasts `ON_CYCLES` cycles, then goes to GAP.
  - When ON ends with `idx`=NUM_DIGITS-1, `idx` wraps to 0. Otherwise `idx` increments.
- In ON, `an_o[idx]`=0 and all other bits are 1, unless digit `idx` is suppressed. A suppressed digit keeps all bits 1.
- Digit `idx` is suppressed when either:
  - `blank_i[idx]`=1, or
  - `lz_en_i`=1, `idx`≠0, and every `shadow` nibble from `idx` up to NUM_DIGITS-1 is 0.
- Digit 0 is never suppressed by leading-zero suppression.
- `digit_o` = `shadow` nibble `idx` in both GAP and ON. A suppressed digit still outputs its nibble.
- Load path:
  - `load_i`=1 sets `pending`=`value_i` and `pend_vld`=1.
  - A later `load_i` before the frame boundary overwrites `pending` (last write wins).
- Frame boundary is the last ON cycle of digit NUM_DIGITS-1. On that edge:
  - If `load_i`=1, `shadow`←`value_i` (bypass).
  - Else if `pend_vld`=1, `shadow`←`pending`.
  - `pend_vld` clears in either case.
- Outputs are registered and glitch-free. `an_o` never has two bits at 0.

## Timing
- Reset values, asserted asynchronously:
  - `an_o`=all ones, `digit_o`=0, `frame_o`=0.
  - `shadow`=0, `pending`=0, `pend_vld`=0, `idx`=0, `cnt`=0, `state`=GAP.
- Slot length S = GAP_CYCLES+ON_CYCLES. Frame length F = NUM_DIGITS·S.
- Cycle n counts from the first rising edge after `rst_i` deasserts (n=0).
- Digit k schedule:
  - Gap in cycles k·S .. k·S+GAP_CYCLES-1.
  - Lit in cycles k·S+GAP_CYCLES .. (k+1)·S-1.
- `frame_o`=1 exactly in cycles F-1, 2F-1, …
- A new value takes effect in `digit_o` from the first cycle of the next frame, i.e. digit 0's gap.
- Latency from `load_i` to display is 1 to F cycles.
- `rst_i` asserted mid-slot or mid-frame: immediate return to reset values. A pending load is discarded.
- `blank_i` and `lz_en_i` changes affect `an_o` on the next edge and are never deferred to the frame boundary.

## Test plan
All scenarios use NUM_DIGITS=4, ON_CYCLES=8, GAP_CYCLES=2 (S=10, F=40).

- **Reset and scan order.** Release reset with `shadow`=0.
  - Cycles 0–1: `an_o`=1111.
  - Cycles 2–9: `an_o`=1110. Cycles 12–19: 1101. Cycles 22–29: 1011. Cycles 32–39: 0111.
  - `frame_o` high only at cycles 39 and 79.
- **Frame-synchronous load.** Pulse `load_i` with `value_i`=16'h1A2F at cycle 15.
  - Cycles 15–39: `digit_o` remains 0.
  - From cycle 40, `digit_o` shows F, 2, A, 1 in successive slots.
- **Boundary and overwrite.**
  - Pulse `load_i` with 16'h1111 at cycle 20, then with 16'h2222 at cycle 39 (the boundary edge).
  - Required: the next frame shows 2222, and `pend_vld`=0 afterwards.
- **Leading-zero suppression.** `shadow`=16'h0005, `lz_en_i`=1.
  - Only digit 0 lights (`an_o`=1110 during its ON). Digits 1–3 stay 1111.
  - With `shadow`=16'h0000, digit 0 still lights showing 0.
  - With `shadow`=16'h0305, digit 3 is off and digits 2, 1, 0 light.
- **Blanking.** `blank_i`=4'b0100.
  - Digit 2's ON window shows `an_o`=1111.
  - Clearing `blank_i` mid-window relights digit 2 on the next edge.
- **Mid-operation reset.**
  - Assert `rst_i` at cycle 25 with a load pending.
  - Required: `an_o`=1111 and `digit_o`=0 immediately.
  - After release, the scan restarts at digit 0 showing 0, and the pending value is never displayed.
